pin_entry_ctrl: RTL and testbench

Keypad front-end that sits directly upstream of the digital lock controller. It assembles two BCD key digits into the 8-bit pin and compares each nibble against a stored code. On ENTER it issues a one-cycle req_access pulse together with held first_four_match / last_four_match flags, which the lock consumes. It also supports re-programming the stored code, gated by the lock's lock_open output.

---
 rtl/pin_entry_pkg.sv | 17 +
 rtl/pin_entry_ctrl_if.sv | 34 +++
 rtl/pin_entry_timer.sv | 36 +++
 rtl/pin_entry_ctrl.sv | 153 +++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pin_entry_pkg.sv
// rtl/pin_entry_pkg.sv - shared widths, limits and entry state encoding for the pin entry block
package pin_entry_pkg;

    localparam int DIGIT_W = 4;
    localparam int PIN_W   = 8;

    // Largest key code that counts as a decimal digit; 10-15 are function keys.
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no digits held
        ONE  = 2'd1,   // first digit held
        TWO  = 2'd2,   // both digits held, waiting for ENTER or prog_req
        HOLD = 2'd3    // request issued, pin and flags held for the lock
    } entry_state_e;

endpackage

// File: rtl/pin_entry_ctrl_if.sv
// rtl/pin_entry_ctrl_if.sv - keypad/lock side signal bundle of the pin entry controller
//
// master : keypad + lock driver (drives key strobes, prog_req, lock_open)
// slave  : pin_entry_ctrl (drives pin, match flags, pulses, digit_cnt)
interface pin_entry_ctrl_if import pin_entry_pkg::*; ();

    logic               key_valid;
    logic [DIGIT_W-1:0] key_code;
    logic               key_enter;
    logic               key_clear;
    logic               prog_req;
    logic               lock_open;

    logic [PIN_W-1:0]   pin;
    logic               first_four_match;
    logic               last_four_match;
    logic               req_access;
    logic               prog_ack;
    logic               timeout_err;
    logic [1:0]         digit_cnt;

    modport master (
        output key_valid, key_code, key_enter, key_clear, prog_req, lock_open,
        input  pin, first_four_match, last_four_match, req_access, prog_ack,
               timeout_err, digit_cnt
    );

    modport slave (
        input  key_valid, key_code, key_enter, key_clear, prog_req, lock_open,
        output pin, first_four_match, last_four_match, req_access, prog_ack,
               timeout_err, digit_cnt
    );

endinterface

// File: rtl/pin_entry_timer.sv
// rtl/pin_entry_timer.sv - inactivity counter with restart/enable and expiry flag
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   restart   : reload the count to 0 on the next edge
//   enable    : count while high; held at 0 while low
//   expired   : high while enabled and the count sits at TIMEOUT_CYC-1
module pin_entry_timer #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart || !enable) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            // Saturate so a missed restart can never wrap into a second expiry.
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/pin_entry_ctrl.sv
// rtl/pin_entry_ctrl.sv - keypad front-end assembling a two-digit pin and comparing it to the stored code
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pin_entry_ctrl_if.slave
//              in : key_valid, key_code, key_enter, key_clear, prog_req, lock_open
//              out: pin, first_four_match, last_four_match, req_access, prog_ack,
//                   timeout_err, digit_cnt (all registered)
module pin_entry_ctrl import pin_entry_pkg::*; #(
    parameter logic [PIN_W-1:0] DEFAULT_PIN = 8'h25,
    parameter int               TIMEOUT_CYC = 1000,
    parameter int               TMR_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    pin_entry_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ONE  = ONE;
    localparam logic [1:0] S_TWO  = TWO;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]       state_q, state_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [PIN_W-1:0] stored_q, stored_d;
    logic             ffm_q, ffm_d;
    logic             lfm_q, lfm_d;
    logic             req_q, req_d;
    logic             ack_q, ack_d;
    logic             tmo_q, tmo_d;
    logic [1:0]       cnt_q, cnt_d;

    logic digit_acc;
    logic tmr_expired;
    logic tmr_enable;
    logic tmr_restart;

    // Only events that actually change something take priority; an ignored
    // ENTER or prog_req lets a lower-priority event in the same cycle through.
    logic enter_eff;
    logic prog_eff;
    logic digit_eff;

    assign enter_eff = bus.key_enter && (state_q != S_HOLD);
    assign prog_eff  = bus.prog_req && bus.lock_open && (state_q == S_TWO);
    assign digit_eff = bus.key_valid && (bus.key_code <= MAX_DIGIT) && (state_q != S_TWO);

    always_comb begin
        state_d   = state_q;
        pin_d     = pin_q;
        stored_d  = stored_q;
        ffm_d     = ffm_q;
        lfm_d     = lfm_q;
        cnt_d     = cnt_q;
        req_d     = 1'b0;
        ack_d     = 1'b0;
        tmo_d     = 1'b0;
        digit_acc = 1'b0;

        if (bus.key_clear) begin
            state_d = S_IDLE;
            pin_d   = '0;
            ffm_d   = 1'b0;
            lfm_d   = 1'b0;
            cnt_d   = 2'd0;
        end else if (enter_eff) begin
            req_d   = 1'b1;
            state_d = S_HOLD;
            if (state_q == S_TWO) begin
                ffm_d = (pin_q[PIN_W-1 -: DIGIT_W] == stored_q[PIN_W-1 -: DIGIT_W]);
                lfm_d = (pin_q[DIGIT_W-1:0] == stored_q[DIGIT_W-1:0]);
            end else begin
                // Short entry: the lock must see a failed attempt.
                ffm_d = 1'b0;
                lfm_d = 1'b0;
            end
        end else if (prog_eff) begin
            ack_d    = 1'b1;
            stored_d = pin_q;
            pin_d    = '0;
            cnt_d    = 2'd0;
            state_d  = S_IDLE;
        end else if (digit_eff) begin
            digit_acc = 1'b1;
            if (state_q == S_ONE) begin
                pin_d[DIGIT_W-1:0] = bus.key_code;
                cnt_d              = 2'd2;
                state_d            = S_TWO;
            end else begin
                pin_d   = {bus.key_code, {DIGIT_W{1'b0}}};
                cnt_d   = 2'd1;
                ffm_d   = 1'b0;
                lfm_d   = 1'b0;
                state_d = S_ONE;
            end
        end else if (tmr_expired) begin
            tmo_d   = 1'b1;
            pin_d   = '0;
            ffm_d   = 1'b0;
            lfm_d   = 1'b0;
            cnt_d   = 2'd0;
            state_d = S_IDLE;
        end
    end

    assign tmr_enable  = (state_q == S_ONE) || (state_q == S_TWO);
    assign tmr_restart = digit_acc || (state_d != state_q);

    pin_entry_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (tmr_restart),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pin_q    <= '0;
            stored_q <= DEFAULT_PIN;
            ffm_q    <= 1'b0;
            lfm_q    <= 1'b0;
            cnt_q    <= 2'd0;
            req_q    <= 1'b0;
            ack_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pin_q    <= pin_d;
            stored_q <= stored_d;
            ffm_q    <= ffm_d;
            lfm_q    <= lfm_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.pin              = pin_q;
    assign bus.first_four_match = ffm_q;
    assign bus.last_four_match  = lfm_q;
    assign bus.req_access       = req_q;
    assign bus.prog_ack         = ack_q;
    assign bus.timeout_err      = tmo_q;
    assign bus.digit_cnt        = cnt_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb/tb_pin_entry_ctrl.sv - scoreboard testbench for pin_entry_ctrl
module tb_pin_entry_ctrl;

    localparam logic [1:0] K_REQ = 2'd1;
    localparam logic [1:0] K_ACK = 2'd2;
    localparam logic [1:0] K_TMO = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] pin;
        logic       ffm;
        logic       lfm;
        int         cyc;   // 0 = arrival cycle not checked
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pin_entry_ctrl_if bus();

    pin_entry_ctrl #(
        .DEFAULT_PIN (8'h25),
        .TIMEOUT_CYC (16),
        .TMR_W       (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- monitor ----------------
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        int   n;
        logic [1:0] got;
        exp_t e;
        if (rst) begin
            prev_pulse = 1'b0;
        end else begin
            n   = int'(bus.req_access) + int'(bus.prog_ack) + int'(bus.timeout_err);
            got = bus.req_access ? K_REQ : (bus.prog_ack ? K_ACK : (bus.timeout_err ? K_TMO : 2'd0));
            if (n != 0) begin
                checks++;
                if (n > 1) begin
                    errors++;
                    $display("FAIL pulse_excl: %0d pulses high together, required 1", n);
                end
                checks++;
                if (prev_pulse) begin
                    errors++;
                    $display("FAIL pulse_width: pulse kind %0d longer than one cycle at cyc %0d", got, cyc);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got pulse kind %0d pin=%h at cyc %0d, required none", got, bus.pin, cyc);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.kind || bus.pin !== e.pin ||
                        bus.first_four_match !== e.ffm || bus.last_four_match !== e.lfm) begin
                        errors++;
                        $display("FAIL sb_resp: got kind=%0d pin=%h ffm=%b lfm=%b, required kind=%0d pin=%h ffm=%b lfm=%b",
                                 got, bus.pin, bus.first_four_match, bus.last_four_match,
                                 e.kind, e.pin, e.ffm, e.lfm);
                    end
                    if (e.cyc != 0) begin
                        checks++;
                        if (cyc != e.cyc) begin
                            errors++;
                            $display("FAIL sb_cycle: got pulse at cyc %0d, required cyc %0d", cyc, e.cyc);
                        end
                    end
                    if (e.kind != K_REQ) begin
                        checks++;
                        if (bus.digit_cnt !== 2'd0) begin
                            errors++;
                            $display("FAIL sb_cnt: got digit_cnt=%0d, required 0", bus.digit_cnt);
                        end
                    end
                end
            end
            prev_pulse = (n != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic enter();
        bus.key_enter = 1'b1;
        tick();
        bus.key_enter = 1'b0;
    endtask

    task automatic clear();
        bus.key_clear = 1'b1;
        tick();
        bus.key_clear = 1'b0;
    endtask

    task automatic prog();
        bus.prog_req = 1'b1;
        tick();
        bus.prog_req = 1'b0;
    endtask

    task automatic expect_pulse(input logic [1:0] k, input logic [7:0] p,
                                input logic f, input logic l, input int c);
        exp_t e;
        e.kind = k;
        e.pin  = p;
        e.ffm  = f;
        e.lfm  = l;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {17'd0, bus.pin, bus.first_four_match, bus.last_four_match,
                bus.req_access, bus.prog_ack, bus.timeout_err, bus.digit_cnt};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int c1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
        bus.prog_req  = 1'b0;
        bus.lock_open = 1'b0;

        ticks(3);
        chk("reset_outs", all_outs(), 32'd0);
        rst = 1'b0;
        tick();

        // 1: correct code, flags held
        key(4'd2); key(4'd5); enter();
        expect_pulse(K_REQ, 8'h25, 1'b1, 1'b1, 0);
        ticks(5);
        chk("t1_hold", {bus.first_four_match, bus.last_four_match, bus.pin}, {1'b1, 1'b1, 8'h25});

        // 2: second digit wrong, then a new digit drops the flags
        key(4'd2); key(4'd7); enter();
        expect_pulse(K_REQ, 8'h27, 1'b1, 1'b0, 0);
        ticks(2);
        key(4'd9);
        chk("t2_newdig", {bus.first_four_match, bus.last_four_match, bus.pin, bus.digit_cnt},
            {1'b0, 1'b0, 8'h90, 2'd1});

        // 3: short entry, repeated ENTER ignored
        clear();
        key(4'd3); enter();
        expect_pulse(K_REQ, 8'h30, 1'b0, 1'b0, 0);
        ticks(2);
        enter();
        ticks(4);
        chk("t3_pin_kept", bus.pin, 8'h30);

        // 4: timeout 16 cycles after the key; CLEAR suppresses it
        clear();
        key(4'd4);
        c1 = cyc;
        expect_pulse(K_TMO, 8'h00, 1'b0, 1'b0, c1 + 16);
        ticks(25);
        chk("t4_after_tmo", {bus.pin, bus.digit_cnt}, 10'd0);
        key(4'd4); ticks(3); clear();
        ticks(30);
        chk("t4_clear_outs", all_outs(), 32'd0);

        // 5: programming gated by lock_open
        key(4'd1); key(4'd1);
        bus.lock_open = 1'b0;
        prog();
        ticks(2);
        chk("t5_prog_locked", {bus.pin, bus.digit_cnt}, {8'h11, 2'd2});
        bus.lock_open = 1'b1;
        prog();
        expect_pulse(K_ACK, 8'h00, 1'b0, 1'b0, 0);
        bus.lock_open = 1'b0;
        ticks(2);
        key(4'd1); key(4'd1); enter();
        expect_pulse(K_REQ, 8'h11, 1'b1, 1'b1, 0);
        ticks(2);
        key(4'd2); key(4'd5); enter();
        expect_pulse(K_REQ, 8'h25, 1'b0, 1'b0, 0);
        ticks(2);

        // 6: asynchronous reset mid-entry and after programming
        key(4'd3);
        #2 rst = 1'b1;
        #1 chk("t6_async_one", all_outs(), 32'd0);
        ticks(2);
        rst = 1'b0;
        tick();
        key(4'd1); key(4'd1);
        bus.lock_open = 1'b1;
        prog();
        expect_pulse(K_ACK, 8'h00, 1'b0, 1'b0, 0);
        bus.lock_open = 1'b0;
        key(4'd1); key(4'd1); enter();
        expect_pulse(K_REQ, 8'h11, 1'b1, 1'b1, 0);
        ticks(2);
        #2 rst = 1'b1;
        #1 chk("t6_async_hold", all_outs(), 32'd0);
        ticks(2);
        rst = 1'b0;
        tick();
        key(4'd2); key(4'd5); enter();
        expect_pulse(K_REQ, 8'h25, 1'b1, 1'b1, 0);
        ticks(2);

        // 7: non-digit key codes ignored
        clear();
        key(4'hA);
        chk("t7_ignored", {bus.pin, bus.digit_cnt}, 10'd0);
        key(4'd2); key(4'hA); key(4'd5); enter();
        expect_pulse(K_REQ, 8'h25, 1'b1, 1'b1, 0);
        ticks(2);

        // 8: CLEAR beats ENTER in the same cycle
        key(4'd2); key(4'd5);
        bus.key_clear = 1'b1;
        bus.key_enter = 1'b1;
        tick();
        bus.key_clear = 1'b0;
        bus.key_enter = 1'b0;
        ticks(3);
        chk("t8_clear_wins", all_outs(), 32'd0);

        ticks(5);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
